// File: rtl/fifo_pkg.sv
// Shared FIFO pointer types and Gray-code helpers for the read- and write-side controllers.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 4;
  localparam logic RST_EMPTY = 1'b1;

  typedef logic [FIFO_ADDR_W:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    for (int i = 0; i < FIFO_ADDR_W + 1; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int i = 0; i < W; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/rptr_empty_ctrl.sv
// Read-domain pointer and status controller for the async FIFO: pointers, empty/almost-empty,
// occupancy level, read-valid strobe and sticky underflow.
module rptr_empty_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int AE_THRESH = 2
) (
  input  logic              r_clk,
  input  logic              rrst,
  input  logic              r_en,
  input  logic [ADDR_W:0]   wptr_gray_sync,
  input  logic              uf_clr,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   rptr,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              f_empty,
  output logic              f_aempty,
  output logic [ADDR_W:0]   rd_level,
  output logic              rd_valid,
  output logic              underflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_rptr_gray;
  logic          r_f_empty;
  logic          r_f_aempty;
  logic [PW-1:0] r_rd_level;
  logic          r_rd_valid;
  logic          r_underflow;

  logic          w_rd_acc;
  logic [PW-1:0] w_b_next;
  logic [PW-1:0] w_g_next;
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_level_next;

  gray2bin_conv #(.W(PW)) u_wptr_conv (
    .i_gray (wptr_gray_sync),
    .o_bin  (w_wbin)
  );

  // Accept only against the registered empty flag, so an underflow read never moves the pointer.
  assign w_rd_acc     = r_en & ~r_f_empty;
  assign w_b_next     = r_rptr + {{ADDR_W{1'b0}}, w_rd_acc};
  assign w_g_next     = (w_b_next >> 1) ^ w_b_next;
  assign w_level_next = w_wbin - w_b_next;

  always_ff @(posedge r_clk) begin
    if (rrst) begin
      r_rptr      <= '0;
      r_rptr_gray <= '0;
      r_f_empty   <= RST_EMPTY;
      r_f_aempty  <= 1'b1;
      r_rd_level  <= '0;
      r_rd_valid  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rptr      <= w_b_next;
      r_rptr_gray <= w_g_next;
      r_f_empty   <= (w_g_next == wptr_gray_sync);
      r_f_aempty  <= (w_level_next <= AE_T);
      r_rd_level  <= w_level_next;
      r_rd_valid  <= w_rd_acc;
      r_underflow <= (r_en & r_f_empty) | (r_underflow & ~uf_clr);
    end
  end

  assign raddr     = r_rptr[ADDR_W-1:0];
  assign rptr      = r_rptr;
  assign rptr_gray = r_rptr_gray;
  assign f_empty   = r_f_empty;
  assign f_aempty  = r_f_aempty;
  assign rd_level  = r_rd_level;
  assign rd_valid  = r_rd_valid;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Scoreboard bench for rptr_empty_ctrl: directed vectors push expectations, a monitor pops and checks.
module tb_rptr_empty_ctrl;

  logic       r_clk = 1'b0;
  logic       rrst;
  logic       r_en;
  logic [4:0] wptr_gray_sync;
  logic       uf_clr;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic [4:0] rptr_gray;
  logic       f_empty;
  logic       f_aempty;
  logic [4:0] rd_level;
  logic       rd_valid;
  logic       underflow;

  always #5 r_clk = ~r_clk;

  rptr_empty_ctrl #(.ADDR_W(4), .AE_THRESH(2)) dut (
    .r_clk          (r_clk),
    .rrst           (rrst),
    .r_en           (r_en),
    .wptr_gray_sync (wptr_gray_sync),
    .uf_clr         (uf_clr),
    .raddr          (raddr),
    .rptr           (rptr),
    .rptr_gray      (rptr_gray),
    .f_empty        (f_empty),
    .f_aempty       (f_aempty),
    .rd_level       (rd_level),
    .rd_valid       (rd_valid),
    .underflow      (underflow)
  );

  typedef struct packed {
    logic [4:0] rptr;
    logic       emp;
    logic       ae;
    logic [4:0] lvl;
    logic       vld;
    logic       uf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [4:0] g(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic ren, input logic [4:0] wg, input logic ufc,
                       input logic [4:0] e_rptr, input logic e_emp, input logic e_ae,
                       input logic [4:0] e_lvl, input logic e_vld, input logic e_uf);
    exp_t e;
    @(negedge r_clk);
    rrst           = rst;
    r_en           = ren;
    wptr_gray_sync = wg;
    uf_clr         = ufc;
    e.rptr = e_rptr; e.emp = e_emp; e.ae = e_ae; e.lvl = e_lvl; e.vld = e_vld; e.uf = e_uf;
    exp_q.push_back(e);
  endtask

  exp_t m;
  always @(posedge r_clk) begin
    #1;
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      chk("rptr",      int'(rptr),      int'(m.rptr));
      chk("raddr",     int'(raddr),     int'(m.rptr[3:0]));
      chk("rptr_gray", int'(rptr_gray), int'(m.rptr ^ (m.rptr >> 1)));
      chk("f_empty",   int'(f_empty),   int'(m.emp));
      chk("f_aempty",  int'(f_aempty),  int'(m.ae));
      chk("rd_level",  int'(rd_level),  int'(m.lvl));
      chk("rd_valid",  int'(rd_valid),  int'(m.vld));
      chk("underflow", int'(underflow), int'(m.uf));
    end
  end

  initial begin
    int n;
    rrst = 1'b1; r_en = 1'b1; wptr_gray_sync = 5'b00011; uf_clr = 1'b0;

    // reset held two cycles with read requested and a non-empty write pointer
    drive(1, 1, 5'b00011, 0,  5'd0, 1, 1, 5'd0, 0, 0);
    drive(1, 1, 5'b00011, 0,  5'd0, 1, 1, 5'd0, 0, 0);
    // five words written, then read down to empty
    drive(0, 0, 5'b00111, 0,  5'd0, 0, 0, 5'd5, 0, 0);
    drive(0, 1, 5'b00111, 0,  5'd1, 0, 0, 5'd4, 1, 0);
    drive(0, 1, 5'b00111, 0,  5'd2, 0, 0, 5'd3, 1, 0);
    drive(0, 1, 5'b00111, 0,  5'd3, 0, 1, 5'd2, 1, 0);
    drive(0, 1, 5'b00111, 0,  5'd4, 0, 1, 5'd1, 1, 0);
    drive(0, 1, 5'b00111, 0,  5'd5, 1, 1, 5'd0, 1, 0);
    // underflow: set, set-wins-over-clear, clear
    drive(0, 1, 5'b00111, 0,  5'd5, 1, 1, 5'd0, 0, 1);
    drive(0, 1, 5'b00111, 1,  5'd5, 1, 1, 5'd0, 0, 1);
    drive(0, 0, 5'b00111, 1,  5'd5, 1, 1, 5'd0, 0, 0);
    drive(0, 0, 5'b00111, 0,  5'd5, 1, 1, 5'd0, 0, 0);
    // write advance alone, then together with an accepted read
    drive(0, 0, 5'b00101, 0,  5'd5, 0, 1, 5'd1, 0, 0);
    drive(0, 1, 5'b00100, 0,  5'd6, 0, 1, 5'd1, 1, 0);
    // level 3, then reset with a read pending
    drive(0, 0, 5'b01101, 0,  5'd6, 0, 0, 5'd3, 0, 0);
    drive(1, 1, 5'b01101, 0,  5'd0, 1, 1, 5'd0, 0, 0);
    // walk the pointer to 30 keeping two words buffered
    drive(0, 0, g(2), 0,      5'd0, 0, 1, 5'd2, 0, 0);
    for (int i = 0; i < 28; i++)
      drive(0, 1, g(i + 3), 0, 5'(i + 1), 0, 1, 5'd2, 1, 0);
    drive(0, 1, g(31), 0,     5'd29, 0, 1, 5'd2, 1, 0);
    drive(0, 1, g(0), 0,      5'd30, 0, 1, 5'd2, 1, 0);
    drive(0, 0, 5'b00011, 0,  5'd30, 0, 0, 5'd4, 0, 0);
    // wrap: 31 -> 0 -> 1 -> 2
    drive(0, 1, 5'b00011, 0,  5'd31, 0, 0, 5'd3, 1, 0);
    drive(0, 1, 5'b00011, 0,  5'd0,  0, 1, 5'd2, 1, 0);
    drive(0, 1, 5'b00011, 0,  5'd1,  0, 1, 5'd1, 1, 0);
    drive(0, 1, 5'b00011, 0,  5'd2,  1, 1, 5'd0, 1, 0);
    drive(0, 0, 5'b00011, 0,  5'd2,  1, 1, 5'd0, 0, 0);

    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge r_clk);
      #2;
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
